// File: rtl/qos_wrr_scheduler_pkg.sv
// Shared constants and FSM encoding for the QoS weighted round-robin scheduler.
package qos_wrr_scheduler_pkg;
  localparam int DATA_W  = 12;
  localparam int N_CLASS = 4;
  localparam int WGT_W   = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_HOLD  = 2'd2
  } state_t;
endpackage

// File: rtl/qos_rr_pick.sv
// Rotating-priority picker: first eligible class at or after rr_ptr, wrapping modulo N_CLASS.
module qos_rr_pick
  import qos_wrr_scheduler_pkg::*;
(
  input  logic [N_CLASS-1:0] eligible,
  input  logic [1:0]         rr_ptr,
  output logic               found,
  output logic [1:0]         idx
);
  logic [1:0] cand;

  // Scan farthest-first so the class nearest to rr_ptr overwrites the others.
  always_comb begin
    found = 1'b0;
    idx   = rr_ptr;
    cand  = rr_ptr;
    for (int i = N_CLASS - 1; i >= 0; i--) begin
      cand = rr_ptr + 2'(i);
      if (eligible[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end
endmodule

// File: rtl/qos_wrr_scheduler.sv
// Credit-based weighted round-robin drain of four class FIFOs into one output FIFO.
// Define QOS_STRICT_PRIO_EN to give class 0 strict priority at every turn boundary.
module qos_wrr_scheduler
  import qos_wrr_scheduler_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset_L,
  input  logic                     active,
  input  logic [N_CLASS-1:0]       empty,
  input  logic [DATA_W-1:0]        fifo_out_0,
  input  logic [DATA_W-1:0]        fifo_out_1,
  input  logic [DATA_W-1:0]        fifo_out_2,
  input  logic [DATA_W-1:0]        fifo_out_3,
  input  logic                     almost_full,
  input  logic                     cfg_load,
  input  logic [N_CLASS*WGT_W-1:0] weight_in,
  output logic [N_CLASS-1:0]       pop,
  output logic                     push,
  output logic [DATA_W-1:0]        data_out,
  output logic [1:0]               grant_idx,
  output logic                     busy,
  output state_t                   state,
  output logic [WGT_W-1:0]         credit
);
  // Handshake: pop[c] is a one-cycle read strobe, only raised on a non-empty FIFO; the
  // word appears on fifo_out_c the next cycle and is forwarded with push high that cycle.

  logic [N_CLASS-1:0][WGT_W-1:0] weight;
  logic [N_CLASS-1:0]            eligible;
  logic [N_CLASS-1:0]            pick_elig;
  logic [1:0]                    rr_ptr, rr_nx, grant_nx, pick_ptr, pick_idx, sel_idx, pop_idx;
  logic [WGT_W-1:0]              credit_nx;
  logic [DATA_W-1:0]             fifo_sel, held;
  logic                          pick_found, sel_found, no_credit, can_pop;
  state_t                        state_nx;

  always_comb begin
    eligible = '0;
    for (int c = 0; c < N_CLASS; c++) begin
      eligible[c] = !empty[c] && (weight[c] != '0);
    end
  end

  // In GRANT the picker re-arbitrates for the next turn, excluding the current owner.
  assign pick_elig = (state == S_IDLE) ? eligible : (eligible & ~(4'b0001 << grant_idx));
  assign pick_ptr  = (state == S_IDLE) ? rr_ptr : (grant_idx + 2'd1);

  qos_rr_pick u_pick (
    .eligible (pick_elig),
    .rr_ptr   (pick_ptr),
    .found    (pick_found),
    .idx      (pick_idx)
  );

`ifdef QOS_STRICT_PRIO_EN
  assign sel_found = pick_elig[0] | pick_found;
  assign sel_idx   = pick_elig[0] ? 2'd0 : pick_idx;
  assign no_credit = (grant_idx == 2'd0);
`else
  assign sel_found = pick_found;
  assign sel_idx   = pick_idx;
  assign no_credit = 1'b0;
`endif

  assign can_pop = (state == S_GRANT) && active && !empty[grant_idx] && !almost_full &&
                   ((credit != '0) || no_credit);
  assign pop     = can_pop ? (4'b0001 << grant_idx) : 4'b0000;
  assign busy    = (state != S_IDLE);

  always_comb begin
    state_nx  = state;
    grant_nx  = grant_idx;
    credit_nx = credit;
    rr_nx     = rr_ptr;
    case (state)
      S_IDLE: begin
        if (active && sel_found) begin
          state_nx  = S_GRANT;
          grant_nx  = sel_idx;
          credit_nx = weight[sel_idx];
        end
      end
      S_GRANT: begin
        if (!active || almost_full) begin
          state_nx = S_HOLD;
        end else begin
          if (can_pop && !no_credit) credit_nx = credit - WGT_W'(1);
          // Turn ends on the credit-exhausting pop, or when the owner runs dry.
          if (!can_pop || (!no_credit && credit == WGT_W'(1))) begin
            rr_nx = grant_idx + 2'd1;
            if (sel_found) begin
              grant_nx  = sel_idx;
              credit_nx = weight[sel_idx];
            end else begin
              state_nx = S_IDLE;
            end
          end
        end
      end
      S_HOLD: begin
        if (active && !almost_full) state_nx = S_GRANT;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state     <= S_IDLE;
      grant_idx <= 2'd0;
      credit    <= '0;
      rr_ptr    <= 2'd0;
      weight    <= {N_CLASS{WGT_W'(1)}};
      push      <= 1'b0;
      pop_idx   <= 2'd0;
      held      <= '0;
    end else begin
      state     <= state_nx;
      grant_idx <= grant_nx;
      credit    <= credit_nx;
      rr_ptr    <= rr_nx;
      if (cfg_load && state == S_IDLE) weight <= weight_in;
      push      <= |pop;
      if (|pop) pop_idx <= grant_idx;
      held      <= data_out;
    end
  end

  // Read data lands the cycle after pop, so it is steered by the registered pop index.
  always_comb begin
    case (pop_idx)
      2'd0:    fifo_sel = fifo_out_0;
      2'd1:    fifo_sel = fifo_out_1;
      2'd2:    fifo_sel = fifo_out_2;
      default: fifo_sel = fifo_out_3;
    endcase
  end

  assign data_out = push ? fifo_sel : held;
endmodule
